mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the word-addressed `memory` block.
- Shares memory between the CPU instruction-fetch port (read-only) and the data port (read/write, optional byte write).
- Serialises one transaction at a time.
- Drives the memory's read/write address, write enable and write data, and returns read data using a registered req/ack handshake per requester.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, grant ids,
// and the latched-transaction record.
package mem_arbiter_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_WAIT  = 3'd1;
    localparam logic [2:0] ST_WR_START = 3'd2;
    localparam logic [2:0] ST_WR_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    localparam logic GNT_D  = 1'b0;
    localparam logic GNT_IF = 1'b1;

    typedef struct packed {
        logic id;   // port that owns the in-flight transaction
        logic we;   // 1 = write (data port only)
    } txn_t;

    function automatic logic other_port(input logic g);
        return (g == GNT_D) ? GNT_IF : GNT_D;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention, else data port always wins.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = if_req | d_req;
        grant_id    = GNT_D;
        if (if_req && d_req)
            grant_id = other_port(last_grant);
        else if (if_req)
            grant_id = GNT_IF;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = if_req | d_req;
        grant_id    = GNT_D;
        if (if_req && !d_req)
            grant_id = GNT_IF;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the word-addressed memory: serialises
// fetch reads and data reads/writes. Optional MEM_ARB_ROUND_ROBIN_EN fairness.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr_read,
    output logic [ADDR_W-1:0] mem_addr_write,
    output logic              mem_en_write,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_write_byte,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_ready,
    input  logic              mem_written,
    output logic              busy
);

    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY);

    logic [2:0] state;
    logic [2:0] cnt;
    txn_t       txn;
    logic       last_grant;
    logic       grant_valid;
    logic       grant_id;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Reset value "fetch granted last" makes the data port win the first tie.
    logic last_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_q <= GNT_IF;
        else if (state == ST_IDLE && grant_valid)
            last_q <= grant_id;
    end
    assign last_grant = last_q;
`else
    assign last_grant = GNT_D;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            txn            <= '0;
            busy           <= 1'b0;
            if_ack         <= 1'b0;
            d_ack          <= 1'b0;
            if_rdata       <= '0;
            d_rdata        <= '0;
            mem_addr_read  <= '0;
            mem_addr_write <= '0;
            mem_en_write   <= 1'b0;
            mem_data_write <= '0;
            mem_write_byte <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        busy   <= 1'b1;
                        txn.id <= grant_id;
                        if (grant_id == GNT_D && d_we) begin
                            txn.we         <= 1'b1;
                            mem_addr_write <= d_addr;
                            mem_data_write <= d_wdata;
                            mem_write_byte <= d_byte;
                            mem_en_write   <= 1'b1;
                            state          <= ST_WR_START;
                        end else begin
                            txn.we        <= 1'b0;
                            mem_addr_read <= (grant_id == GNT_D) ? d_addr : if_addr;
                            cnt           <= CNT_INIT;
                            state         <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else if (mem_ready) begin
                        if (txn.id == GNT_IF) begin
                            if_rdata <= mem_out;
                            if_ack   <= 1'b1;
                        end else begin
                            d_rdata <= mem_out;
                            d_ack   <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_WR_START: begin
                    mem_en_write <= 1'b0;
                    state        <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (mem_written && txn.we) begin
                        d_ack <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Requests seen here belong to the finished transaction.
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    if_ack       <= 1'b0;
                    d_ack        <= 1'b0;
                    mem_en_write <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory plus a reference
// word store, directed scenarios and randomized single transactions.
module tb_mem_arbiter;

    localparam int L  = 1;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic          d_byte = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr_read;
    logic [AW-1:0] mem_addr_write;
    logic          mem_en_write;
    logic [DW-1:0] mem_data_write;
    logic          mem_write_byte;
    logic [DW-1:0] mem_out;
    logic          mem_ready;
    logic          mem_written = 1'b0;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.READ_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr_read(mem_addr_read), .mem_addr_write(mem_addr_write),
        .mem_en_write(mem_en_write), .mem_data_write(mem_data_write),
        .mem_write_byte(mem_write_byte), .mem_out(mem_out),
        .mem_ready(mem_ready), .mem_written(mem_written), .busy(busy)
    );

    // Behavioural memory: 64 words, fixed read latency, ready gated by a stall window.
    logic [31:0] mem [64];
    logic [31:0] rd_pipe [L];
    int cyc = 0;
    int stall_until = 0;
    assign mem_ready = (cyc >= stall_until);
    assign mem_out   = rd_pipe[L-1];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        rd_pipe[0] <= mem[mem_addr_read[7:2]];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
        mem_written <= mem_en_write;
        if (mem_en_write) begin
            if (mem_write_byte)
                mem[mem_addr_write[7:2]][8*mem_addr_write[1:0] +: 8] <= mem_data_write[7:0];
            else
                mem[mem_addr_write[7:2]] <= mem_data_write;
        end
    end

    logic [31:0] ref_mem [64];

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic bw);
        if (bw) ref_mem[a[7:2]][8*a[1:0] +: 8] = d[7:0];
        else    ref_mem[a[7:2]] = d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one request from IDLE, waits (bounded) for its ack, returns to IDLE.
    task automatic run_txn(input logic port_if, input logic we, input logic bw,
                           input logic [31:0] addr, input logic [31:0] wd, input int stall,
                           output int lat, output logic got_if, output logic got_d,
                           output logic [31:0] rd, output int en_cycles, output logic [31:0] a_seen);
        lat = 0; got_if = 1'b0; got_d = 1'b0; rd = '0; en_cycles = 0; a_seen = '0;
        if (stall > 0) stall_until = cyc + stall;
        if (port_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_byte = bw; d_addr = addr; d_wdata = wd;
        end
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 1) a_seen = (we && !port_if) ? mem_addr_write : mem_addr_read;
            if (mem_en_write) en_cycles++;
            if (if_ack || d_ack) begin
                lat = k; got_if = if_ack; got_d = d_ack;
                rd = if_ack ? if_rdata : d_rdata;
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({if_ack, d_ack, busy, mem_en_write, mem_write_byte} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 00000", {if_ack, d_ack, busy, mem_en_write, mem_write_byte});
        end
        n_cmp++;
        if ({mem_addr_read, mem_addr_write, mem_data_write} !== 96'b0) begin
            n_bad++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr_read, mem_addr_write, mem_data_write});
        end
        n_cmp++;
        if ({if_rdata, d_rdata} !== 64'b0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    // Populate every word through the data port so later reads have known contents.
    task automatic test_fill();
        int lat, en; logic gi, gd; logic [31:0] rd, a, d, as;
        for (int i = 0; i < 64; i++) begin
            a = 32'(i * 4);
            d = $urandom;
            run_txn(1'b0, 1'b1, 1'b0, a, d, 0, lat, gi, gd, rd, en, as);
            ref_write(a, d, 1'b0);
            n_cmp++;
            if (lat !== 3 || gi !== 1'b0 || gd !== 1'b1 || en !== 1) begin
                n_bad++; $display("FAIL fill_write[%0d]: lat=%0d if=%b d=%b en=%0d want lat=3 if=0 d=1 en=1", i, lat, gi, gd, en);
            end
        end
    endtask

    task automatic test_single_fetch();
        int lat, en; logic gi, gd; logic [31:0] rd, as;
        run_txn(1'b0, 1'b1, 1'b0, 32'h8, 32'h0C200001, 0, lat, gi, gd, rd, en, as);
        ref_write(32'h8, 32'h0C200001, 1'b0);
        if_req = 1'b1; if_addr = 32'h8;
        for (int k = 1; k <= L + 3; k++) begin
            tick();
            n_cmp++;
            if (if_ack !== (k == L + 2) || d_ack !== 1'b0 || busy !== (k <= L + 2)) begin
                n_bad++; $display("FAIL fetch_edge%0d: if_ack=%b d_ack=%b busy=%b want %b 0 %b",
                                  k, if_ack, d_ack, busy, (k == L + 2), (k <= L + 2));
            end
            if (k == L + 2) begin
                n_cmp++;
                if (if_rdata !== 32'h0C200001) begin
                    n_bad++; $display("FAIL fetch_rdata: got %h want 0c200001", if_rdata);
                end
                if_req = 1'b0;
            end
        end
        n_cmp++;
        if (if_rdata !== 32'h0C200001) begin
            n_bad++; $display("FAIL fetch_rdata_held: got %h want 0c200001", if_rdata);
        end
    endtask

    task automatic test_write_read();
        int lat, en; logic gi, gd; logic [31:0] rd, as;
        run_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 0, lat, gi, gd, rd, en, as);
        ref_write(32'h40, 32'hDEADBEEF, 1'b0);
        n_cmp++;
        if (en !== 1 || gd !== 1'b1 || gi !== 1'b0 || as !== 32'h40) begin
            n_bad++; $display("FAIL wr_deadbeef: en=%0d d=%b if=%b addr=%h want 1 1 0 40", en, gd, gi, as);
        end
        run_txn(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 0, lat, gi, gd, rd, en, as);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || gd !== 1'b1 || lat !== L + 2) begin
            n_bad++; $display("FAIL rd_deadbeef: got %h lat=%0d d=%b want deadbeef lat=%0d d=1", rd, lat, gd, L + 2);
        end
        run_txn(1'b0, 1'b1, 1'b1, 32'h41, 32'h123456A5, 0, lat, gi, gd, rd, en, as);
        ref_write(32'h41, 32'h123456A5, 1'b1);
        run_txn(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 0, lat, gi, gd, rd, en, as);
        n_cmp++;
        if (rd !== ref_mem[16]) begin
            n_bad++; $display("FAIL byte_write: got %h want %h", rd, ref_mem[16]);
        end
    endtask

    task automatic test_random();
        int lat, en, st; logic gi, gd, pif, we, bw; logic [31:0] rd, a, d, as;
        for (int i = 0; i < 40; i++) begin
            pif = 1'($urandom_range(0, 1));
            we  = pif ? 1'b0 : 1'($urandom_range(0, 1));
            bw  = we ? 1'($urandom_range(0, 1)) : 1'b0;
            a   = {24'($urandom), 8'($urandom_range(0, 255))};
            d   = $urandom;
            st  = we ? 0 : $urandom_range(0, 3);
            run_txn(pif, we, bw, a, d, st, lat, gi, gd, rd, en, as);
            n_cmp++;
            if (gi !== pif || gd !== !pif || as !== a) begin
                n_bad++; $display("FAIL rand_ack[%0d]: if=%b d=%b addr=%h want if=%b d=%b addr=%h", i, gi, gd, as, pif, !pif, a);
            end
            if (we) begin
                ref_write(a, d, bw);
                n_cmp++;
                if (en !== 1 || lat !== 3) begin
                    n_bad++; $display("FAIL rand_wr[%0d]: en=%0d lat=%0d want 1 3", i, en, lat);
                end
            end else begin
                n_cmp++;
                if (rd !== ref_mem[a[7:2]] || (st == 0 && lat !== L + 2)) begin
                    n_bad++; $display("FAIL rand_rd[%0d]: got %h lat=%0d want %h", i, rd, lat, ref_mem[a[7:2]]);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic exp_if;
        int   got;
        reset = 1'b0; tick(); reset = 1'b1; tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h20;
        got = 0;
        for (int k = 0; k < 100 && got < 6; k++) begin
            tick();
            if (if_ack && d_ack) begin
                n_cmp++; n_bad++; $display("FAIL both_acks: got if=1 d=1 want at most one");
            end
            if (if_ack || d_ack) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                exp_if = got[0];
`else
                exp_if = 1'b0;
`endif
                n_cmp++;
                if (if_ack !== exp_if || (exp_if ? if_rdata : d_rdata) !== (exp_if ? ref_mem[8] : ref_mem[4])) begin
                    n_bad++; $display("FAIL contend_grant%0d: if_ack=%b want %b", got, if_ack, exp_if);
                end
                got++;
            end
        end
        n_cmp++;
        if (got !== 6) begin
            n_bad++; $display("FAIL contend_count: got %0d want 6", got);
        end
        d_req = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (if_ack) got = 1;
            n_cmp++;
            if (d_ack !== 1'b0) begin
                n_bad++; $display("FAIL contend_tail_d: got d_ack=1 want 0");
            end
        end
        n_cmp++;
        if (got !== 1 || if_rdata !== ref_mem[8]) begin
            n_bad++; $display("FAIL contend_fetch_second: got %0d/%h want 1/%h", got, if_rdata, ref_mem[8]);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        int ack_edge;
        ack_edge = (L + 2 > 6) ? L + 2 : 6;
        stall_until = cyc + 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        for (int k = 1; k <= ack_edge; k++) begin
            tick();
            n_cmp++;
            if (d_ack !== (k == ack_edge) || busy !== 1'b1) begin
                n_bad++; $display("FAIL stall_edge%0d: d_ack=%b busy=%b want %b 1", k, d_ack, busy, (k == ack_edge));
            end
        end
        n_cmp++;
        if (d_rdata !== ref_mem[16]) begin
            n_bad++; $display("FAIL stall_rdata: got %h want %h", d_rdata, ref_mem[16]);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int acks, lat, en; logic gi, gd; logic [31:0] rd, as;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        tick();
        n_cmp++;
        if (mem_en_write !== 1'b1) begin
            n_bad++; $display("FAIL midwr_en_pre: got %b want 1", mem_en_write);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en_write, busy, if_ack, d_ack} !== 4'b0) begin
            n_bad++; $display("FAIL midwr_async_clear: got %b want 0000", {mem_en_write, busy, if_ack, d_ack});
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        reset = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (if_ack || d_ack || busy) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin
            n_bad++; $display("FAIL midwr_stale: got %0d active cycles want 0", acks);
        end
        run_txn(1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 0, lat, gi, gd, rd, en, as);
        n_cmp++;
        if (rd !== ref_mem[32]) begin
            n_bad++; $display("FAIL midwr_nowrite: got %h want %h", rd, ref_mem[32]);
        end
    endtask

    task automatic test_held_req();
        int acks, ack_k;
        acks = 0; ack_k = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (d_ack) begin acks++; ack_k = k; end
            if (ack_k > 0 && k == ack_k + 1) d_req = 1'b0;
        end
        d_req = 1'b0;
        n_cmp++;
        if (acks !== 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL held_req: got %0d acks busy=%b want 1 0", acks, busy);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single_fetch();
        test_write_read();
        test_random();
        test_contention();
        test_stall();
        test_reset_mid_write();
        test_held_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
